// File: rtl/lotr_mem_loader.sv
// lotr_mem_loader: byte-stream program loader for a gpc_4t tile; writes I/D memory words and holds cores in reset until GO.
// Optional trailing checksum byte is enabled by defining LOTR_LOADER_CHKSUM_EN.
module lotr_mem_loader #(
    parameter logic [31:0] I_MEM_OFFSET = 32'h0000_0000,
    parameter logic [31:0] SIZE_I_MEM   = 32'h0000_1000,
    parameter logic [31:0] D_MEM_OFFSET = 32'h0040_0000,
    parameter logic [31:0] SIZE_D_MEM   = 32'h0000_2000
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        RxValid,
    input  logic [7:0]  RxData,
    output logic        RxReady,
    output logic        MemWrEn,
    output logic        MemWrSel,
    output logic [31:0] MemWrAddr,
    output logic [31:0] MemWrData,
    input  logic        MemWrReady,
    output logic        CoreRstQnnnH,
    output logic        LoadDone,
    output logic        LoadErr
);
    localparam logic [7:0] CMD_LOAD_I = 8'hA5;
    localparam logic [7:0] CMD_LOAD_D = 8'h5A;
    localparam logic [7:0] CMD_GO     = 8'hC3;

`ifdef LOTR_LOADER_CHKSUM_EN
    typedef enum logic [3:0] {IDLE, ADDR, CNT, CHECK, DATA, WRITE, DONE, ERR, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, CNT, CHECK, DATA, WRITE, DONE, ERR} state_t;
`endif

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [15:0] remain;
    logic [23:0] shift;
    logic        rx_fire;
    logic [32:0] base33;
    logic [32:0] limit33;
    logic [32:0] end33;
    logic        range_bad;

    assign rx_fire = RxValid & RxReady;

    // MemWrAddr doubles as the running address counter, so the range test reads it directly.
    always_comb begin
        base33    = MemWrSel ? {1'b0, D_MEM_OFFSET} : {1'b0, I_MEM_OFFSET};
        limit33   = base33 + (MemWrSel ? {1'b0, SIZE_D_MEM} : {1'b0, SIZE_I_MEM});
        end33     = {1'b0, MemWrAddr} + {15'd0, remain, 2'b00};
        range_bad = (MemWrAddr[1:0] != 2'b00) || ({1'b0, MemWrAddr} < base33) || (end33 > limit33);
    end

`ifdef LOTR_LOADER_CHKSUM_EN
    logic [7:0] chk_sum;
    always_ff @(posedge QClk) begin
        if (RstQnnnH || state == IDLE) begin
            chk_sum <= 8'h00;
        end else if (rx_fire) begin
            chk_sum <= chk_sum + RxData;
        end
    end
`endif

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            state        <= IDLE;
            RxReady      <= 1'b0;
            MemWrEn      <= 1'b0;
            MemWrSel     <= 1'b0;
            MemWrAddr    <= 32'd0;
            MemWrData    <= 32'd0;
            CoreRstQnnnH <= 1'b1;
            LoadDone     <= 1'b0;
            LoadErr      <= 1'b0;
            byte_cnt     <= 2'd0;
            remain       <= 16'd0;
            shift        <= 24'd0;
        end else begin
            LoadDone <= 1'b0;
            case (state)
                IDLE: begin
                    RxReady <= 1'b1;
                    if (rx_fire) begin
                        byte_cnt <= 2'd0;
                        if (RxData == CMD_LOAD_I || RxData == CMD_LOAD_D) begin
                            MemWrSel     <= (RxData == CMD_LOAD_D);
                            CoreRstQnnnH <= 1'b1;
                            LoadErr      <= 1'b0;
                            state        <= ADDR;
                        end else if (RxData == CMD_GO) begin
                            CoreRstQnnnH <= 1'b0;
                        end else begin
                            RxReady <= 1'b0;
                            state   <= ERR;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        MemWrAddr <= {RxData, MemWrAddr[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= CNT;
                        end
                    end
                end
                CNT: begin
                    if (rx_fire) begin
                        remain   <= {RxData, remain[15:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd1) begin
                            byte_cnt <= 2'd0;
                            RxReady  <= 1'b0;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (range_bad) begin
                        state <= ERR;
                    end else if (remain == 16'd0) begin
`ifdef LOTR_LOADER_CHKSUM_EN
                        RxReady  <= 1'b1;
                        state    <= CHK;
`else
                        LoadDone <= 1'b1;
                        state    <= DONE;
`endif
                    end else begin
                        RxReady <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        shift    <= {RxData, shift[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            MemWrData <= {RxData, shift};
                            MemWrEn   <= 1'b1;
                            RxReady   <= 1'b0;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (MemWrReady) begin
                        MemWrEn   <= 1'b0;
                        MemWrAddr <= MemWrAddr + 32'd4;
                        remain    <= remain - 16'd1;
                        if (remain == 16'd1) begin
`ifdef LOTR_LOADER_CHKSUM_EN
                            RxReady  <= 1'b1;
                            state    <= CHK;
`else
                            LoadDone <= 1'b1;
                            state    <= DONE;
`endif
                        end else begin
                            RxReady <= 1'b1;
                            state   <= DATA;
                        end
                    end
                end
                DONE: begin
                    RxReady <= 1'b1;
                    state   <= IDLE;
                end
                ERR: begin
                    LoadErr <= 1'b1;
                    RxReady <= 1'b1;
                    state   <= IDLE;
                end
`ifdef LOTR_LOADER_CHKSUM_EN
                CHK: begin
                    if (rx_fire) begin
                        RxReady <= 1'b0;
                        if ((chk_sum + RxData) == 8'h00) begin
                            LoadDone <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
`endif
                default: begin
                    RxReady <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lotr_mem_loader.sv
// Directed bench for lotr_mem_loader; checksum steps follow LOTR_LOADER_CHKSUM_EN.
module tb_lotr_mem_loader;
    logic        QClk = 1'b0;
    logic        RstQnnnH = 1'b1;
    logic        RxValid = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxReady;
    logic        MemWrEn;
    logic        MemWrSel;
    logic [31:0] MemWrAddr;
    logic [31:0] MemWrData;
    logic        MemWrReady = 1'b1;
    logic        CoreRstQnnnH;
    logic        LoadDone;
    logic        LoadErr;

    int checks = 0;
    int errors = 0;

    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          en_cycles = 0;
    logic [31:0] mon_addr [0:31];
    logic [31:0] mon_data [0:31];
    logic        mon_sel  [0:31];

    int w0, d0, e0;

    lotr_mem_loader dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .RxValid(RxValid), .RxData(RxData),
        .RxReady(RxReady), .MemWrEn(MemWrEn), .MemWrSel(MemWrSel),
        .MemWrAddr(MemWrAddr), .MemWrData(MemWrData), .MemWrReady(MemWrReady),
        .CoreRstQnnnH(CoreRstQnnnH), .LoadDone(LoadDone), .LoadErr(LoadErr)
    );

    always #5 QClk = ~QClk;

    always @(negedge QClk) begin
        if (MemWrEn) en_cycles <= en_cycles + 1;
        if (LoadDone) done_cnt <= done_cnt + 1;
        if (MemWrEn && MemWrReady && wr_cnt < 32) begin
            mon_addr[wr_cnt] <= MemWrAddr;
            mon_data[wr_cnt] <= MemWrData;
            mon_sel[wr_cnt]  <= MemWrSel;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge QClk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        RxValid = 1'b1;
        RxData  = b;
        while (!RxReady && n < 40) begin
            tick(1);
            n++;
        end
        if (n >= 40) check("rx_ready_timeout", 32'(RxReady), 32'd1);
        tick(1);
        RxValid = 1'b0;
        RxData  = 8'h00;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] cnt);
        send_byte(cmd);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(addr[23:16]);
        send_byte(addr[31:24]);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxready"}, 32'(RxReady), 32'd0);
        check({tag, "_wren"},    32'(MemWrEn), 32'd0);
        check({tag, "_sel"},     32'(MemWrSel), 32'd0);
        check({tag, "_addr"},    MemWrAddr, 32'd0);
        check({tag, "_data"},    MemWrData, 32'd0);
        check({tag, "_corerst"}, 32'(CoreRstQnnnH), 32'd1);
        check({tag, "_done"},    32'(LoadDone), 32'd0);
        check({tag, "_err"},     32'(LoadErr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick(3);
        check_reset_outputs("rst");
        RstQnnnH = 1'b0;
        tick(1);
        check("idle_rxready", 32'(RxReady), 32'd1);

        // Two-word I_MEM load with MemWrReady high
        w0 = wr_cnt; d0 = done_cnt;
        send_hdr(8'hA5, 32'h0000_0000, 16'd2);
        send_word(32'h0000_0013);
        check("t1_latency_en", 32'(MemWrEn), 32'd1);
        check("t1_latency_data", MemWrData, 32'h0000_0013);
        send_word(32'h0000_006F);
`ifdef LOTR_LOADER_CHKSUM_EN
        send_byte(8'h7C);
`endif
        tick(6);
        check("t1_wr_count", 32'(wr_cnt - w0), 32'd2);
        check("t1_w0_sel",  32'(mon_sel[w0]), 32'd0);
        check("t1_w0_addr", mon_addr[w0], 32'h0000_0000);
        check("t1_w0_data", mon_data[w0], 32'h0000_0013);
        check("t1_w1_sel",  32'(mon_sel[w0+1]), 32'd0);
        check("t1_w1_addr", mon_addr[w0+1], 32'h0000_0004);
        check("t1_w1_data", mon_data[w0+1], 32'h0000_006F);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_err", 32'(LoadErr), 32'd0);
        check("t1_corerst", 32'(CoreRstQnnnH), 32'd1);

        // D_MEM load with back-pressure on the write
        w0 = wr_cnt; d0 = done_cnt;
        send_hdr(8'h5A, 32'h0040_0010, 16'd1);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        MemWrReady = 1'b0;
        e0 = en_cycles;
        send_byte(8'hDE);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_en",   32'(MemWrEn), 32'd1);
            check("t2_hold_addr", MemWrAddr, 32'h0040_0010);
            check("t2_hold_data", MemWrData, 32'hDEAD_BEEF);
            check("t2_hold_rxready", 32'(RxReady), 32'd0);
            tick(1);
        end
        MemWrReady = 1'b1;
        tick(1);
        check("t2_en_dropped", 32'(MemWrEn), 32'd0);
`ifdef LOTR_LOADER_CHKSUM_EN
        send_byte(8'h77);
`endif
        tick(4);
        check("t2_en_cycles", 32'(en_cycles - e0), 32'd4);
        check("t2_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("t2_sel",  32'(mon_sel[w0]), 32'd1);
        check("t2_addr", mon_addr[w0], 32'h0040_0010);
        check("t2_data", mon_data[w0], 32'hDEAD_BEEF);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // GO releases cores; a following load command re-asserts their reset
        check("t3_corerst_before_go", 32'(CoreRstQnnnH), 32'd1);
        send_byte(8'hC3);
        check("t3_corerst_after_go", 32'(CoreRstQnnnH), 32'd0);
        check("t3_go_stays_idle", 32'(RxReady), 32'd1);
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        check("t3_corerst_after_load", 32'(CoreRstQnnnH), 32'd1);
        // Continue as a misaligned packet
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        tick(3);
        check("t4_misaligned_err", 32'(LoadErr), 32'd1);
        check("t4_misaligned_idle", 32'(RxReady), 32'd1);
        check("t4_misaligned_nowr", 32'(wr_cnt - w0), 32'd0);
        check("t4_misaligned_nodone", 32'(done_cnt - d0), 32'd0);

        // GO still accepted with LoadErr set, and leaves LoadErr alone
        send_byte(8'hC3);
        check("t4_go_with_err_corerst", 32'(CoreRstQnnnH), 32'd0);
        check("t4_go_keeps_err", 32'(LoadErr), 32'd1);

        // Overrun of I_MEM end: 0xFFC + 8 > 0x1000
        send_byte(8'hA5);
        check("t5_load_clears_err", 32'(LoadErr), 32'd0);
        send_byte(8'hFC);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        tick(3);
        check("t5_range_err", 32'(LoadErr), 32'd1);
        check("t5_range_nowr", 32'(wr_cnt - w0), 32'd0);

        // D_MEM address just below its base
        send_hdr(8'h5A, 32'h003F_FFFC, 16'd1);
        tick(3);
        check("t5_below_base_err", 32'(LoadErr), 32'd1);
        check("t5_below_base_nowr", 32'(wr_cnt - w0), 32'd0);

        // Last word of I_MEM exactly fits; clears LoadErr
        d0 = done_cnt;
        send_hdr(8'hA5, 32'h0000_0FFC, 16'd1);
        send_word(32'h0403_0201);
`ifdef LOTR_LOADER_CHKSUM_EN
        send_byte(8'hEA);
`endif
        tick(4);
        check("t5_edge_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("t5_edge_addr", mon_addr[w0], 32'h0000_0FFC);
        check("t5_edge_data", mon_data[w0], 32'h0403_0201);
        check("t5_edge_done", 32'(done_cnt - d0), 32'd1);
        check("t5_edge_err_cleared", 32'(LoadErr), 32'd0);

        // Unknown command
        w0 = wr_cnt;
        send_byte(8'h77);
        tick(2);
        check("t6_unknown_err", 32'(LoadErr), 32'd1);
        check("t6_unknown_nowr", 32'(wr_cnt - w0), 32'd0);

        // Reset after two bytes of a data word
        send_hdr(8'hA5, 32'h0000_0000, 16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        RstQnnnH = 1'b1;
        tick(2);
        check_reset_outputs("t7_midrst");
        RstQnnnH = 1'b0;
        tick(2);
        check("t7_midrst_nowr", 32'(wr_cnt - w0), 32'd0);
        d0 = done_cnt;
        send_hdr(8'hA5, 32'h0000_0008, 16'd1);
        send_word(32'h4433_2211);
`ifdef LOTR_LOADER_CHKSUM_EN
        send_byte(8'h4D);
`endif
        tick(4);
        check("t7_after_rst_wr", 32'(wr_cnt - w0), 32'd1);
        check("t7_after_rst_addr", mon_addr[w0], 32'h0000_0008);
        check("t7_after_rst_data", mon_data[w0], 32'h4433_2211);
        check("t7_after_rst_done", 32'(done_cnt - d0), 32'd1);

`ifdef LOTR_LOADER_CHKSUM_EN
        // Corrupted checksum: word still written, error instead of done
        w0 = wr_cnt; d0 = done_cnt;
        send_hdr(8'h5A, 32'h0040_0000, 16'd1);
        send_word(32'h0000_0001);
        send_byte(8'h00);
        tick(4);
        check("t8_badsum_wr", 32'(wr_cnt - w0), 32'd1);
        check("t8_badsum_data", mon_data[w0], 32'h0000_0001);
        check("t8_badsum_err", 32'(LoadErr), 32'd1);
        check("t8_badsum_nodone", 32'(done_cnt - d0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
